// File: rtl/branch_resolve.sv
// Resolves EX-stage branches/jumps: registered predictor update, fetch redirect and flush sequencing.
// Optional perf counters are built only when BRANCH_RESOLVE_PERF_CNT_EN is defined.
module branch_resolve #(
   parameter int unsigned FLUSH_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ex_valid,
   input  logic        ex_is_branch,
   input  logic        ex_is_jump,
   input  logic [31:0] ex_PC,
   input  logic [31:0] ex_target,
   input  logic        ex_cond_taken,
   input  logic [31:0] ex_pred_next_PC,
   output logic [31:0] updata_PC,
   output logic        updata_taken,
   output logic        updata_enable,
   output logic        redirect_valid,
   output logic [31:0] redirect_PC,
   output logic        flush,
   output logic [31:0] perf_branch_cnt,
   output logic [31:0] perf_mispred_cnt,
   output logic        dbg_state
);

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_FLUSH = 1'b1
   } state_e;

   localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

   state_e      state_q, state_d;
   logic [3:0]  flush_cnt_q, flush_cnt_d;
   logic        upd_en_q, upd_en_d;
   logic [31:0] upd_pc_q, upd_pc_d;
   logic        upd_taken_q, upd_taken_d;
   logic        redir_valid_q, redir_valid_d;
   logic [31:0] redir_pc_q, redir_pc_d;

   logic        accepted;
   logic        actual_taken;
   logic [31:0] actual_next;
   logic        mispredict;

   always_comb begin
      accepted     = ex_valid && (ex_is_branch || ex_is_jump) && (state_q == ST_IDLE);
      actual_taken = ex_is_jump || ex_cond_taken;
      actual_next  = actual_taken ? ex_target : (ex_PC + 32'd4);
      mispredict   = accepted && (actual_next != ex_pred_next_PC);
   end

   always_comb begin
      state_d       = state_q;
      flush_cnt_d   = flush_cnt_q;
      upd_en_d      = 1'b0;
      upd_pc_d      = upd_pc_q;
      upd_taken_d   = upd_taken_q;
      redir_valid_d = 1'b0;
      redir_pc_d    = redir_pc_q;

      // A branch with the jump bit also set is treated as a jump and does not train the predictor.
      if (accepted && ex_is_branch && !ex_is_jump) begin
         upd_en_d    = 1'b1;
         upd_pc_d    = ex_PC;
         upd_taken_d = ex_cond_taken;
      end

      if (mispredict) begin
         redir_valid_d = 1'b1;
         redir_pc_d    = actual_next;
      end

      case (state_q)
         ST_IDLE: begin
            if (mispredict) begin
               state_d     = ST_FLUSH;
               flush_cnt_d = FLUSH_LOAD;
            end
         end
         ST_FLUSH: begin
            if (flush_cnt_q == 4'd0) begin
               state_d = ST_IDLE;
            end else begin
               flush_cnt_d = flush_cnt_q - 4'd1;
            end
         end
         default: begin
            state_d     = ST_IDLE;
            flush_cnt_d = 4'd0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= ST_IDLE;
         flush_cnt_q   <= 4'd0;
         upd_en_q      <= 1'b0;
         upd_pc_q      <= 32'd0;
         upd_taken_q   <= 1'b0;
         redir_valid_q <= 1'b0;
         redir_pc_q    <= 32'd0;
      end else begin
         state_q       <= state_d;
         flush_cnt_q   <= flush_cnt_d;
         upd_en_q      <= upd_en_d;
         upd_pc_q      <= upd_pc_d;
         upd_taken_q   <= upd_taken_d;
         redir_valid_q <= redir_valid_d;
         redir_pc_q    <= redir_pc_d;
      end
   end

   assign updata_enable  = upd_en_q;
   assign updata_PC      = upd_pc_q;
   assign updata_taken   = upd_taken_q;
   assign redirect_valid = redir_valid_q;
   assign redirect_PC    = redir_pc_q;
   assign flush          = (state_q == ST_FLUSH);
   assign dbg_state      = state_q;

`ifdef BRANCH_RESOLVE_PERF_CNT_EN
   logic [31:0] br_cnt_q, br_cnt_d;
   logic [31:0] mp_cnt_q, mp_cnt_d;

   // Both counters saturate instead of wrapping.
   always_comb begin
      br_cnt_d = br_cnt_q;
      mp_cnt_d = mp_cnt_q;
      if (accepted && (br_cnt_q != 32'hFFFF_FFFF)) br_cnt_d = br_cnt_q + 32'd1;
      if (mispredict && (mp_cnt_q != 32'hFFFF_FFFF)) mp_cnt_d = mp_cnt_q + 32'd1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         br_cnt_q <= 32'd0;
         mp_cnt_q <= 32'd0;
      end else begin
         br_cnt_q <= br_cnt_d;
         mp_cnt_q <= mp_cnt_d;
      end
   end

   assign perf_branch_cnt  = br_cnt_q;
   assign perf_mispred_cnt = mp_cnt_q;
`else
   assign perf_branch_cnt  = 32'd0;
   assign perf_mispred_cnt = 32'd0;
`endif

endmodule
